// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq: W=N*WORDS add/subtract sequenced over one N-bit slice, LSB slice first.
// Define MP_ADDSUB_SEQ_OVF_EN to add the registered signed-overflow output.
module mp_addsub_seq #(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   a,
   input  logic [N*WORDS-1:0]   b,
   input  logic                 sub,
   input  logic                 carry_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   result,
   output logic                 carry_out,
   output logic                 busy
`ifdef MP_ADDSUB_SEQ_OVF_EN
   ,output logic                overflow
`endif
);
   localparam int W  = N * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic          c_q, c_d, sub_q, sub_d, co_q, co_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
   logic [N-1:0]  bx;
   logic [N:0]    s;
`ifdef MP_ADDSUB_SEQ_OVF_EN
   logic          ovf_q, ovf_d;
`endif

   // Operands shift right one slice per cycle, so the active slice is always bits [N-1:0].
   assign bx = sub_q ? ~b_q[N-1:0] : b_q[N-1:0];
   assign s  = {1'b0, a_q[N-1:0]} + {1'b0, bx} + {{N{1'b0}}, c_q};

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      c_d     = c_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      res_d   = res_q;
      co_d    = co_q;
`ifdef MP_ADDSUB_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            sub_d   = sub;
            c_d     = sub ^ carry_in;
            k_d     = '0;
         end
         RUN: begin
            a_d   = a_q >> N;
            b_d   = b_q >> N;
            c_d   = s[N];
            res_d = (res_q >> N) | (W'(s[N-1:0]) << (W - N));
            k_d   = k_q + KW'(1);
            if (k_q == KW'(WORDS - 1)) begin
               state_d = DONE;
               co_d    = s[N];
`ifdef MP_ADDSUB_SEQ_OVF_EN
               // carry into the MSB recovered from the MSB sum bit
               ovf_d   = s[N] ^ s[N-1] ^ a_q[N-1] ^ bx[N-1];
`endif
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         c_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         res_q   <= '0;
         co_q    <= 1'b0;
`ifdef MP_ADDSUB_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         c_q     <= c_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         res_q   <= res_d;
         co_q    <= co_d;
`ifdef MP_ADDSUB_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign busy      = state_q != IDLE;
   assign result    = res_q;
   assign carry_out = co_q;
`ifdef MP_ADDSUB_SEQ_OVF_EN
   assign overflow  = ovf_q;
`endif
endmodule

// File: doc/mp_addsub_seq.md
Name: mp_addsub_seq

Overview:
- Multi-precision add/subtract sequencer. Computes a W-bit add or subtract (W = N*WORDS) by time-multiplexing one N-bit ripple-carry add/sub slice over WORDS cycles, LSB slice first.
- The carry is chained between slices through an internal register.
- Valid/ready handshake on the operand and result sides.
- Lets wide arithmetic reuse the existing narrow adder slice instead of a W-bit ripple chain.

Parameters:
- N, default 4: slice width in bits, N >= 1.
- WORDS, default 4: number of slices per operation, WORDS >= 1. W = N*WORDS.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept an operation.
- a  input  W  operand A.
- b  input  W  operand B.
- sub  input  1  0 = add, 1 = subtract.
- carry_in  input  1  carry-in when adding, borrow-in when subtracting.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer accepts the result.
- result  output  W  sum or difference.
- carry_out  output  1  carry out of the MSB slice; for subtract, 1 = no borrow.
- busy  output  1  high in RUN or DONE.
- overflow  output  1  signed overflow; only present with OVF_EN (see Optional Feature).

Behaviour:
- Reset is synchronous and active-high on clk. While rst is high at an edge: state = IDLE, in_ready=1, out_valid=0, busy=0, result=0, carry_out=0, overflow=0, and the slice index and carry register are cleared.
- Reset mid-operation aborts and discards the operation; no result is produced.
- Slice equation, with k the slice index and c the carry register:
  - S = a_k + (sub ? ~b_k : b_k) + c, computed at N+1 bits.
  - result_k <= S[N-1:0]; c <= S[N].
  - Initial c = sub ? ~carry_in : carry_in.
  - Net effect: sub=0 gives A+B+carry_in; sub=1 gives A-B-carry_in. All arithmetic is modulo 2^W.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge t: capture a, b and sub into internal registers, load the initial carry, set k=0, go to RUN.
  - Port changes after the accept edge have no effect on the operation.
- RUN:
  - in_ready=0, busy=1.
  - Slice k is computed in the cycle after edge t+k and registered at edge t+k+1.
  - At the edge that registers slice WORDS-1 (edge t+WORDS): carry_out <= final carry, out_valid <= 1, go to DONE.
  - Latency: out_valid is high exactly WORDS cycles after the accept edge. With WORDS=1, the latency is 1 cycle.
- DONE:
  - out_valid=1; result, carry_out and overflow are held stable; in_ready=0.
  - in_valid is ignored.
  - On out_valid && out_ready at an edge: out_valid <= 0, go to IDLE. in_ready is 1 in the following cycle.
  - No same-cycle accept in DONE, so the minimum period per operation is WORDS+2 cycles.
- result may show partial values during RUN. It is only meaningful while out_valid=1.
- Every register has a reset value. No combinational path from the inputs to in_ready or out_valid.

Optional Feature:
- Macro: MP_ADDSUB_SEQ_OVF_EN.
- When defined:
  - Port overflow exists.
  - At the final slice, overflow <= carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow of the W-bit operation.
  - overflow is registered together with carry_out and cleared on reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (N=4, WORDS=4, W=16):
1. a=0x1234, b=0x0FED, sub=0, carry_in=0, out_ready=1 -> result=0x2221, carry_out=0. out_valid rises exactly 4 cycles after the accept edge; in_ready is 0 from accept until one cycle after the result handshake.
2. Carry across all slices: a=0xFFFF, b=0x0001, sub=0, carry_in=0 -> result=0x0000, carry_out=1. Same inputs with carry_in=1 -> result=0x0001, carry_out=1.
3. Subtract:
   - a=0x0005, b=0x0007, sub=1, carry_in=0 -> result=0xFFFE, carry_out=0 (borrow).
   - a=0x0007, b=0x0005, sub=1, carry_in=1 -> result=0x0001, carry_out=1.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid and drive a new in_valid with different a/b -> result and carry_out stay stable, the new request is not accepted, busy=1. Then out_ready=1 for 1 cycle -> next cycle out_valid=0, in_ready=1, and the pending request is accepted.
5. Reset mid-operation: assert rst for 1 cycle 2 cycles after accept -> next cycle state is IDLE, in_ready=1, out_valid=0, result=0, carry_out=0. No out_valid pulse for the aborted operation. A following operation 0x0001+0x0001 returns 0x0002.
6. With MP_ADDSUB_SEQ_OVF_EN:
   - 0x7FFF+0x0001 -> result=0x8000, overflow=1.
   - 0x8000-0x0001 -> result=0x7FFF, overflow=1.
   - 0x0003+0x0004 -> overflow=0.
   - Without the macro, the bench compiles with no overflow port and cases 1–5 pass unchanged.
